// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word and RAM state encodings plus the memory arbiter FSM states.
package cpu_types_pkg;

   localparam int unsigned WORD_BITS = 32;
   typedef logic [WORD_BITS-1:0] word_t;

   typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

   typedef enum logic [2:0] {IDLE, IACC, DACC, IRESP, DRESP} arb_state_t;

   localparam int unsigned ARB_TIMEOUT_DEF = 64;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Access-state watchdog for mem_arbiter; only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic CLK,
   input  logic RST,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC) > 8) ? $clog2(TIMEOUT_CYC) : 8;

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign expired = enable && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data has priority over fetch, one-cycle registered hits.
// Optional access watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned WORD_W      = 32,
   parameter int unsigned TIMEOUT_CYC = ARB_TIMEOUT_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   output logic              ihit,
   output logic [WORD_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              dhit,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  ramstate_t         ramstate,
   output logic              busy,
   output logic              mem_err
);

   if (TIMEOUT_CYC < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 2");
   end

   arb_state_t        state_q, state_d;
   logic [WORD_W-1:0] iload_q, iload_d;
   logic [WORD_W-1:0] dload_q, dload_d;
   logic              mem_err_q, mem_err_d;
   logic              ihit_q, dhit_q;
   logic              in_acc;
   logic              timed_out;

   assign in_acc = (state_q == IACC) || (state_q == DACC);

`ifdef MEM_TIMEOUT_EN
   mem_timeout_ctr #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .CLK     (CLK),
      .RST     (RST),
      .clear   (~in_acc),
      .enable  (in_acc),
      .expired (timed_out)
   );
`else
   assign timed_out = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      iload_d   = iload_q;
      dload_d   = dload_q;
      mem_err_d = mem_err_q;
      ramREN    = 1'b0;
      ramWEN    = 1'b0;
      ramaddr   = '0;
      ramstore  = '0;

      unique case (state_q)
         IDLE: begin
            if (dREN || dWEN) begin
               state_d = DACC;
            end else if (iREN) begin
               state_d = IACC;
            end
         end
         IACC: begin
            ramaddr = iaddr;
            ramREN  = iREN;
            if (!iREN) begin
               state_d = IDLE;
            end else if (ramstate == ACCESS) begin
               iload_d = ramload;
               state_d = IRESP;
            end else if (ramstate == ERROR || timed_out) begin
               mem_err_d = 1'b1;
               state_d   = IDLE;
            end
         end
         DACC: begin
            // write wins when both strobes are high
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            if (!dREN && !dWEN) begin
               state_d = IDLE;
            end else if (ramstate == ACCESS) begin
               if (!dWEN) begin
                  dload_d = ramload;
               end
               state_d = DRESP;
            end else if (ramstate == ERROR || timed_out) begin
               mem_err_d = 1'b1;
               state_d   = IDLE;
            end
         end
         IRESP, DRESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         iload_q   <= '0;
         dload_q   <= '0;
         mem_err_q <= 1'b0;
         ihit_q    <= 1'b0;
         dhit_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         iload_q   <= iload_d;
         dload_q   <= dload_d;
         mem_err_q <= mem_err_d;
         ihit_q    <= (state_d == IRESP);
         dhit_q    <= (state_d == DRESP);
      end
   end

   assign ihit    = ihit_q;
   assign dhit    = dhit_q;
   assign iload   = iload_q;
   assign dload   = dload_q;
   assign mem_err = mem_err_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter; define MEM_TIMEOUT_EN to also exercise the watchdog.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned TCYC = 8;
`else
   localparam int unsigned TCYC = 64;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
   logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
   ramstate_t   ramstate = FREE;
   logic        ihit, dhit, ramREN, ramWEN, busy, mem_err;
   logic [31:0] iload, dload, ramaddr, ramstore;

   typedef struct packed {
      logic        is_d;
      logic [31:0] data;
   } sb_t;

   sb_t         sb_q[$];
   sb_t         mon_e;
   int          checks = 0;
   int          errors = 0;
   int          ihits = 0;
   int          dhits = 0;
   logic [31:0] exp_dload = '0;

   mem_arbiter #(
      .WORD_W      (32),
      .TIMEOUT_CYC (TCYC)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .ihit     (ihit),
      .iload    (iload),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .dhit     (dhit),
      .dload    (dload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate),
      .busy     (busy),
      .mem_err  (mem_err)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Hits are matched in order against the expectations queued at stimulus time.
   always @(negedge CLK) begin
      if (!RST && (ihit || dhit)) begin
         check_eq("dual_hit", 32'(ihit & dhit), 32'd0);
         if (sb_q.size() == 0) begin
            check_eq("sb_nonempty", 32'(sb_q.size()), 32'd1);
         end else begin
            mon_e = sb_q.pop_front();
            check_eq("hit_kind", 32'(dhit), 32'(mon_e.is_d));
            if (dhit) check_eq("dload", dload, mon_e.data);
            else      check_eq("iload", iload, mon_e.data);
         end
         if (ihit) ihits++;
         if (dhit) dhits++;
      end
   end

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_ihit"},     32'(ihit),   32'd0);
      check_eq({tag, "_dhit"},     32'(dhit),   32'd0);
      check_eq({tag, "_ramREN"},   32'(ramREN), 32'd0);
      check_eq({tag, "_ramWEN"},   32'(ramWEN), 32'd0);
      check_eq({tag, "_ramaddr"},  ramaddr,     32'd0);
      check_eq({tag, "_ramstore"}, ramstore,    32'd0);
      check_eq({tag, "_busy"},     32'(busy),   32'd0);
   endtask

   task automatic do_access(input bit is_d, input bit wen, input logic [31:0] addr,
                            input logic [31:0] store, input logic [31:0] load,
                            input int nbusy, input string tag);
      int i0, d0;
      i0 = ihits;
      d0 = dhits;
      ramstate = BUSY;
      if (is_d) begin
         daddr = addr; dstore = store; dWEN = wen; dREN = !wen;
      end else begin
         iaddr = addr; iREN = 1'b1;
      end
      tick();
      check_eq({tag, "_busy"},    32'(busy),   32'd1);
      check_eq({tag, "_ramaddr"}, ramaddr,     addr);
      check_eq({tag, "_ramREN"},  32'(ramREN), 32'(!wen));
      check_eq({tag, "_ramWEN"},  32'(ramWEN), 32'(wen));
      if (is_d && wen) check_eq({tag, "_ramstore"}, ramstore, store);
      repeat (nbusy) tick();
      ramstate = ACCESS;
      ramload  = load;
      if (is_d && wen) sb_q.push_back('{is_d: 1'b1, data: exp_dload});
      else             sb_q.push_back('{is_d: is_d, data: load});
      if (is_d && !wen) exp_dload = load;
      tick();
      if (is_d) check_eq({tag, "_dhit"}, 32'(dhit), 32'd1);
      else      check_eq({tag, "_ihit"}, 32'(ihit), 32'd1);
      check_eq({tag, "_resp_strobes"}, 32'({ramREN, ramWEN}), 32'd0);
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      ramstate = FREE;
      tick();
      check_eq({tag, "_hit_drop"}, 32'({ihit, dhit}), 32'd0);
      check_eq({tag, "_idle"},     32'(busy),         32'd0);
      check_eq({tag, "_hitcount"}, 32'((ihits - i0) + (dhits - d0)), 32'd1);
   endtask

   initial begin
      int d0, i0;

      // Reset values
      #2;
      check_idle_outputs("rst");
      check_eq("rst_iload",   iload,        32'd0);
      check_eq("rst_dload",   dload,        32'd0);
      check_eq("rst_mem_err", 32'(mem_err), 32'd0);
      tick();
      tick();
      RST = 1'b0;
      tick();

      // Single fetch, two BUSY cycles: hit four edges after the request
      do_access(1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h8C22_0004, 2, "fetch");
      do_access(1'b1, 1'b0, 32'h0000_0180, 32'h0, 32'h1234_5678, 0, "dread");
      do_access(1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 32'h5555_AAAA, 1, "dwrite");
      check_eq("dwrite_dload_hold", dload, 32'h1234_5678);

      // Simultaneous fetch and data read: data first
      iREN = 1'b1; iaddr = 32'h0000_0044;
      dREN = 1'b1; daddr = 32'h0000_0100;
      ramstate = BUSY;
      tick();
      check_eq("sim_first_addr", ramaddr,     32'h0000_0100);
      check_eq("sim_first_ren",  32'(ramREN), 32'd1);
      ramstate = ACCESS; ramload = 32'h1111_2222;
      sb_q.push_back('{is_d: 1'b1, data: 32'h1111_2222});
      exp_dload = 32'h1111_2222;
      tick();
      check_eq("sim_dhit", 32'(dhit), 32'd1);
      check_eq("sim_no_ihit_yet", 32'(ihit), 32'd0);
      dREN = 1'b0; ramstate = BUSY;
      tick();
      check_eq("sim_idle_gap", 32'(busy), 32'd0);
      tick();
      check_eq("sim_second_addr", ramaddr, 32'h0000_0044);
      ramstate = ACCESS; ramload = 32'h3333_4444;
      sb_q.push_back('{is_d: 1'b0, data: 32'h3333_4444});
      tick();
      check_eq("sim_ihit", 32'(ihit), 32'd1);
      iREN = 1'b0; ramstate = FREE;
      tick();

      // ERROR during IACC: sticky mem_err, no ihit
      i0 = ihits;
      iREN = 1'b1; iaddr = 32'h0000_0048; ramstate = BUSY;
      tick();
      ramstate = ERROR;
      tick();
      check_eq("ierr_mem_err", 32'(mem_err), 32'd1);
      check_eq("ierr_idle",    32'(busy),    32'd0);
      iREN = 1'b0; ramstate = FREE;
      tick();
      tick();
      check_eq("ierr_no_ihit", 32'(ihits - i0), 32'd0);

      // dREN dropped mid-DACC: strobes fall at once, no dhit
      d0 = dhits;
      dREN = 1'b1; daddr = 32'h0000_0300; ramstate = BUSY;
      tick();
      tick();
      dREN = 1'b0;
      #1;
      check_eq("abort_ren_drop", 32'(ramREN), 32'd0);
      tick();
      check_eq("abort_idle", 32'(busy), 32'd0);
      tick();
      check_eq("abort_no_dhit", 32'(dhits - d0), 32'd0);

      do_access(1'b0, 1'b0, 32'h0000_0050, 32'h0, 32'hCAFE_F00D, 3, "fetch2");
      check_eq("mem_err_sticky", 32'(mem_err), 32'd1);

      // Reset mid-DACC
      d0 = dhits;
      dREN = 1'b1; daddr = 32'h0000_0400; ramstate = BUSY;
      tick();
      tick();
      check_eq("rmid_busy", 32'(busy), 32'd1);
      #2;
      RST = 1'b1;
      #1;
      check_idle_outputs("rmid");
      check_eq("rmid_dload",   dload,        32'd0);
      check_eq("rmid_mem_err", 32'(mem_err), 32'd0);
      dREN = 1'b0; ramstate = FREE;
      #3;
      RST = 1'b0;
      exp_dload = '0;
      repeat (3) tick();
      check_eq("rmid_no_dhit", 32'(dhits - d0), 32'd0);

`ifdef MEM_TIMEOUT_EN
      // Watchdog: RAM stuck BUSY for TCYC cycles in DACC
      d0 = dhits;
      dREN = 1'b1; daddr = 32'h0000_0500; ramstate = BUSY;
      tick();
      for (int k = 0; k < int'(TCYC); k++) begin
         check_eq("tmo_still_busy", 32'(busy), 32'd1);
         tick();
      end
      dREN = 1'b0; ramstate = FREE;
      check_eq("tmo_idle",    32'(busy),    32'd0);
      check_eq("tmo_mem_err", 32'(mem_err), 32'd1);
      tick();
      check_eq("tmo_no_dhit", 32'(dhits - d0), 32'd0);
`endif

      check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
